axi_lite_regfile_slave: RTL and testbench

AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

---
 rtl/axi_lite_regfile_slave_if.sv | 39 +++
 rtl/axi_lite_regfile_slave.sv | 125 ++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_slave_if.sv
// rtl/axi_lite_regfile_slave_if.sv - AXI-Lite bus bundle between a register-file master and slave
interface axi_lite_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// rtl/axi_lite_regfile_slave.sv - AXI-Lite register file with independent read and write paths
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_lite_regfile_slave_if.slave s
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Held low through reset so every ready is 0 until the first edge after release
    logic                  live;
    logic                  aw_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data;
    logic [BYTES-1:0]      w_strb;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  aw_in_range, ar_in_range;
    logic [IDXW-1:0]       aw_idx, ar_idx;

    assign s.awready = live && !aw_full;
    assign s.wready  = live && !w_full;
    assign s.arready = live && (!rvalid_q || s.rready);
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    assign aw_hs  = s.awvalid && s.awready;
    assign w_hs   = s.wvalid && s.wready;
    assign ar_hs  = s.arvalid && s.arready;
    assign commit = aw_full && w_full && (!bvalid_q || s.bready);

    assign aw_in_range = {1'b0, aw_addr} < LIMIT;
    assign ar_in_range = {1'b0, s.araddr} < LIMIT;
    assign aw_idx      = aw_addr[OFFS +: IDXW];
    assign ar_idx      = s.araddr[OFFS +: IDXW];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Entries can only fill while empty and only drain while full, so accept and commit never collide
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full  <= 1'b0;
            aw_addr  <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s.awaddr;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (s.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && aw_in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb[b]) begin
                    regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // A same-edge write lands after this sample, so a colliding read returns the old value
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_in_range ? regs[ar_idx] : '0;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb/tb_axi_lite_regfile_slave.sv - randomized self-checking bench for the AXI-Lite register file
module tb_axi_lite_regfile_slave;
    localparam int NREGS = 32;
    localparam int SPAN  = NREGS * 4;

    logic aclk;
    logic areset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [NREGS];
    logic [1:0]  exp_b [$];

    axi_lite_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREGS)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s      (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        return (addr < SPAN) ? model[addr[6:2]] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return (addr < SPAN) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_b.push_back(exp_resp(addr));
        if (addr < SPAN) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[addr[6:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_take, w_take;
        int c = 0;
        while (!(aw_done && w_done) && c < 60) begin
            @(negedge aclk);
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.awaddr  = addr;
            bus.wvalid  = !w_done && (c >= w_dly);
            bus.wdata   = data;
            bus.wstrb   = strb;
            #1;
            aw_take = bus.awvalid && bus.awready;
            w_take  = bus.wvalid && bus.wready;
            @(posedge aclk);
            if (aw_take) aw_done = 1;
            if (w_take)  w_done = 1;
            c++;
        end
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("write_accept", {aw_done, w_done}, 2'b11);
        model_write(addr, data, strb);
    endtask

    task automatic collect_b(input int dly);
        bit taken = 0;
        int c = 0;
        repeat (dly) @(negedge aclk);
        while (!taken && c < 60) begin
            @(negedge aclk);
            bus.bready = 1'b1;
            #1;
            if (bus.bvalid) begin
                check("bresp", bus.bresp, exp_b.pop_front());
                taken = 1;
            end
            @(posedge aclk);
            c++;
        end
        @(negedge aclk);
        bus.bready = 1'b0;
        check("b_arrived", taken, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit taken = 0;
        int c = 0;
        while (!taken && c < 60) begin
            @(negedge aclk);
            bus.arvalid = 1'b1;
            bus.araddr  = addr;
            bus.rready  = 1'b0;
            #1;
            taken = bus.arready;
            @(posedge aclk);
            c++;
        end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        #1;
        check("ar_accept", taken, 1'b1);
        check("rvalid_lat1", bus.rvalid, 1'b1);
        check("rdata", bus.rdata, exp_rdata(addr));
        check("rresp", bus.rresp, exp_resp(addr));
        @(negedge aclk);
        check("rdata_hold", {bus.rvalid, bus.rdata}, {1'b1, exp_rdata(addr)});
        bus.rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.rready = 1'b0;
        #1;
        check("rvalid_clr", bus.rvalid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, bus.awready, 1'b0);
        check({tag, "_wready"},  bus.wready,  1'b0);
        check({tag, "_arready"}, bus.arready, 1'b0);
        check({tag, "_bvalid"},  bus.bvalid,  1'b0);
        check({tag, "_rvalid"},  bus.rvalid,  1'b0);
        check({tag, "_bresp"},   bus.bresp,   2'b00);
        check({tag, "_rresp"},   bus.rresp,   2'b00);
        check({tag, "_rdata"},   bus.rdata,   32'h0);
    endtask

    initial begin
        logic [31:0] addr, data;
        logic [3:0]  strb;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        areset = 1'b0;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        #3 areset = 1'b1;
        #1 check_idle_outputs("reset");
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1 check("pre_edge_awready", bus.awready, 1'b0);
        @(negedge aclk);
        check("post_edge_awready", bus.awready, 1'b1);
        check("post_edge_wready",  bus.wready,  1'b1);
        check("post_edge_arready", bus.arready, 1'b1);

        // AW leads W by two cycles
        do_write(32'h0C, 32'hDEADBEEF, 4'hF, 0, 2);
        collect_b(0);
        do_read(32'h0C);

        // W leads AW, partial strobes
        do_write(32'h14, 32'h11223344, 4'hF, 0, 0);
        collect_b(1);
        do_write(32'h14, 32'hAABBCCDD, 4'h5, 2, 0);
        collect_b(0);
        do_read(32'h14);
        check("strb_merge", model[5], 32'h11BB33DD);

        // out of range
        do_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 0);
        collect_b(0);
        do_read(32'h80);
        do_read(32'h0C);

        // read and write commit to register 7 on the same edge
        do_write(32'h1C, 32'h1, 4'hF, 0, 0);
        collect_b(0);
        @(negedge aclk);
        bus.awvalid = 1; bus.awaddr = 32'h1C; bus.wvalid = 1; bus.wdata = 32'h2; bus.wstrb = 4'hF;
        #1 check("same_edge_awready", {bus.awready, bus.wready}, 2'b11);
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0;
        bus.arvalid = 1; bus.araddr = 32'h1C; bus.rready = 0;
        #1 check("same_edge_arready", bus.arready, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        bus.arvalid = 0;
        #1;
        check("same_edge_rdata", {bus.rvalid, bus.rdata}, {1'b1, 32'h1});
        check("same_edge_bvalid", bus.bvalid, 1'b1);
        model_write(32'h1C, 32'h2, 4'hF);
        bus.rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bus.rready = 0;
        collect_b(0);
        do_read(32'h1C);

        // stalled response: second write buffered, third blocked
        do_write(32'h24, 32'h5A5A0001, 4'hF, 0, 0);
        do_write(32'h84, 32'h5A5A0002, 4'hF, 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            bus.awvalid = 1; bus.awaddr = 32'h28; bus.wvalid = 1; bus.wdata = 32'h77; bus.wstrb = 4'hF;
            #1;
            check("stall_ready", {bus.awready, bus.wready}, 2'b00);
            check("stall_bvalid", {bus.bvalid, bus.bresp}, {1'b1, 2'b00});
            @(posedge aclk);
        end
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0;
        repeat (3) @(negedge aclk);
        check("stall_bvalid_late", {bus.bvalid, bus.bresp}, {1'b1, 2'b00});
        collect_b(0);
        collect_b(0);
        do_read(32'h24);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            addr = $urandom_range(0, SPAN + 15);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3));
                collect_b($urandom_range(0, 3));
            end else begin
                do_read(addr);
            end
        end

        // reset with a read response pending and an AW buffered
        @(negedge aclk);
        bus.arvalid = 1; bus.araddr = 32'h0C; bus.rready = 0;
        #1 check("rst_arready", bus.arready, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        bus.arvalid = 0;
        bus.awvalid = 1; bus.awaddr = 32'h10;
        #1 check("rst_awready", bus.awready, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 0;
        #1 check("rst_pending", {bus.rvalid, bus.awready}, 2'b10);
        #2 areset = 1'b1;
        #1 check_idle_outputs("async_reset");
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("post_rst_ready", {bus.awready, bus.wready}, 2'b11);
        bus.wvalid = 1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        bus.wvalid = 0;
        repeat (2) @(negedge aclk);
        check("no_stale_aw", bus.bvalid, 1'b0);
        bus.awvalid = 1; bus.awaddr = 32'h84;
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 0;
        exp_b.push_back(2'b10);
        collect_b(0);
        for (int i = 0; i < NREGS; i++) do_read(32'(i * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
